// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - single-port framebuffer arbiter: scan-out prefetch FIFO plus host writes
module vga_fb_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int WORD_W   = 16,
  parameter int ADDR_W   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic [9:0]        hpos,
  input  logic [9:0]        vpos,
  input  logic              active,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [WORD_W-1:0] host_wdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              pixel,
  output logic              underrun
);

  localparam int SEL_W = $clog2(WORD_W);
  localparam int TOTAL = H_ACTIVE * V_ACTIVE / WORD_W;
  localparam logic [ADDR_W:0] TOTAL_A = (ADDR_W + 1)'(TOTAL);

  generate
    if (WORD_W != (1 << SEL_W) || (H_ACTIVE % WORD_W) != 0 || H_TOTAL <= H_ACTIVE ||
        V_TOTAL <= V_ACTIVE || TOTAL > (1 << ADDR_W)) begin : g_bad_cfg
      $error("vga_fb_arbiter: inconsistent geometry parameters");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [WORD_W-1:0] fifo_head;
  logic [WORD_W-1:0] fifo_tail;
  logic [1:0]        fifo_count;
  logic [ADDR_W:0]   fetch_addr;
  logic              rd_issue;
  logic              rd_valid;

  logic              trigger;
  logic              dreq;
  logic              host_go;
  logic              run_beat;
  logic              pop;
  logic              starve;
  logic [2:0]        occupancy;
  logic [SEL_W-1:0]  bit_sel;

  // Reads in flight count against FIFO space so a returning word always has a slot.
  assign occupancy  = {1'b0, fifo_count} + {2'b0, rd_issue} + {2'b0, rd_valid};
  assign trigger    = clk_en && (vpos == 10'(V_TOTAL - 1)) && (hpos == 10'(H_ACTIVE));
  assign dreq       = (state == RUN) && (occupancy < 3'd2) && (fetch_addr < TOTAL_A);
  assign host_ready = rst_n && !dreq;
  assign host_go    = host_valid && host_ready;

  assign run_beat = clk_en && active && (state == RUN);
  assign pop      = run_beat && (&hpos[SEL_W-1:0]) && (fifo_count != 2'd0);
  assign starve   = run_beat && (fifo_count == 2'd0);

  // WORD_W is a power of two, so WORD_W-1-x is just the bitwise inverse of x.
  assign bit_sel = ~hpos[SEL_W-1:0];
  assign pixel   = ((state == RUN) && active && (fifo_count != 2'd0)) ? fifo_head[bit_sel] : 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      fifo_head  <= '0;
      fifo_tail  <= '0;
      fifo_count <= 2'd0;
      fetch_addr <= '0;
      rd_issue   <= 1'b0;
      rd_valid   <= 1'b0;
      underrun   <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      if (dreq) begin
        mem_en   <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= fetch_addr[ADDR_W-1:0];
      end else if (host_go) begin
        mem_en    <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= host_addr;
        mem_wdata <= host_wdata;
      end else begin
        mem_en <= 1'b0;
        mem_we <= 1'b0;
      end

      // A frame trigger drops any read already on its way back.
      rd_issue <= dreq && !trigger;
      rd_valid <= rd_issue && !trigger;

      if (starve) begin
        underrun <= 1'b1;
      end

      if (trigger) begin
        state      <= RUN;
        fifo_count <= 2'd0;
        fetch_addr <= '0;
      end else begin
        if (starve) begin
          state <= IDLE;
        end
        if (dreq) begin
          fetch_addr <= fetch_addr + 1'b1;
        end
        case ({rd_valid, pop})
          2'b10: begin
            if (fifo_count == 2'd0) begin
              fifo_head <= mem_rdata;
            end else begin
              fifo_tail <= mem_rdata;
            end
            fifo_count <= fifo_count + 2'd1;
          end
          2'b01: begin
            fifo_head  <= fifo_tail;
            fifo_count <= fifo_count - 2'd1;
          end
          2'b11: begin
            if (fifo_count == 2'd1) begin
              fifo_head <= mem_rdata;
            end else begin
              fifo_head <= fifo_tail;
              fifo_tail <= mem_rdata;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Shares one single-port framebuffer RAM between the display scan-out path and a host write port. It sits beside the VGA timing generator and consumes its `hpos`/`vpos`/`active`/`clk_en`. The block prefetches 1bpp pixel words into a 2-entry FIFO ahead of the beam and serialises them to a `pixel` output. Host writes get every memory cycle the display does not need.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `V_ACTIVE`, 480: visible lines
- `H_TOTAL`, 800: pixel clocks per line, matching the timing generator
- `V_TOTAL`, 525: lines per frame
- `WORD_W`, 16: pixels per memory word; must be a power of two; `H_ACTIVE` must be a multiple of it
- `ADDR_W`, 15: word address width; must hold `H_ACTIVE*V_ACTIVE/WORD_W` words (19200 by default)

Ports:
- `clk`  in  1  system clock; the only clock
- `rst_n`  in  1  reset, synchronous, active-low
- `clk_en`  in  1  pixel clock enable, shared with the timing generator
- `hpos`  in  10  timing generator horizontal position
- `vpos`  in  10  timing generator vertical position
- `active`  in  1  timing generator active-region flag
- `host_valid`  in  1  host write request
- `host_ready`  out  1  host write accepted this cycle when `host_valid` is also high
- `host_addr`  in  ADDR_W  host write word address
- `host_wdata`  in  WORD_W  host write data
- `mem_en`  out  1  RAM access strobe, registered
- `mem_we`  out  1  RAM write strobe, registered
- `mem_addr`  out  ADDR_W  RAM word address, registered
- `mem_wdata`  out  WORD_W  RAM write data, registered
- `mem_rdata`  in  WORD_W  RAM read data, valid the cycle after `mem_en && !mem_we`
- `pixel`  out  1  current pixel, combinational
- `underrun`  out  1  sticky flag; display needed a word the FIFO did not have

## Operation
- Words and totals:
  - Word k holds pixels 16k through 16k+15 of raster order, with the MSB as the leftmost pixel.
  - `TOTAL = H_ACTIVE*V_ACTIVE/WORD_W`.
- State machine has two states, `IDLE` and `RUN`. Reset enters `IDLE`.
- Frame trigger:
  - Condition: `clk_en && vpos==V_TOTAL-1 && hpos==H_ACTIVE`, i.e. the start of horizontal blanking on the last line.
  - Action, from either state: go to `RUN`, empty the FIFO, set `fetch_addr=0`, and discard any in-flight read data.
- `RUN` to `IDLE`: on underrun. `underrun` is set to 1 and stays set until reset.
- Display request `dreq`:
  - Asserted when: `RUN`, AND `fifo_count + reads_in_flight < 2`, AND `fetch_addr < TOTAL`.
  - When `dreq` is high: issue a read of `fetch_addr` next cycle, then increment `fetch_addr`.
  - `fetch_addr` stops at `TOTAL` and does not wrap.
- Host port:
  - `host_ready = rst_n && !dreq`.
  - On a handshake: write `host_addr`/`host_wdata` next cycle.
  - Display always has priority over the host.
  - Writes accepted in `IDLE` or `RUN` are identical.
- Read data is pushed into the FIFO in the cycle `mem_rdata` is valid.
- Pixel output:
  - `pixel = (RUN && active && fifo_count>0) ? head[WORD_W-1-hpos[3:0]] : 0`
  - Use `hpos[log2(WORD_W)-1:0]` in general.
- Pop: on `clk_en && active && hpos[3:0]==WORD_W-1 && RUN`.
- Underrun condition: `clk_en && active && RUN && fifo_count==0`.
- Simultaneous push and pop: `fifo_count` is unchanged, and the new word goes behind the head.
- Simultaneous trigger and underrun: the trigger wins. State becomes `RUN` and `underrun` is still set.

## Timing
- Reset, in the cycle after `rst_n` is sampled low:
  - `mem_en=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `underrun=0`
  - State `IDLE`, FIFO empty, `fetch_addr=0`
  - `host_ready=0` while `rst_n` is low
  - `pixel=0`
- Reset mid-frame leaves the block in `IDLE` with `pixel=0` until the next trigger.
- Read latency:
  - grant at cycle N
  - `mem_en=1, mem_we=0` at N+1
  - `mem_rdata` captured into the FIFO at the end of N+2
  - at most 2 reads outstanding
- Write latency: handshake at N; `mem_en=1, mem_we=1` with address and data at N+1.
- When no access is granted, `mem_en=0` the next cycle. `mem_addr`/`mem_wdata` hold their last values.
- Bandwidth:
  - Display uses one memory cycle per `WORD_W` pixel enables.
  - The host is guaranteed at least `WORD_W-1` of every `WORD_W` pixel periods, when `clk_en` is asserted no faster than every cycle.
- Prefill: the trigger leaves `H_TOTAL-H_ACTIVE` pixel clocks to fill both FIFO entries before pixel (0,0).

## Test plan
- Reset, then run one full frame with memory word k = k[15:0] and the host idle:
  - first frame: `pixel=0` throughout, state `IDLE`
  - second frame: line 0 pixels 0–15 = 0x0000 and pixels 16–31 = 0x0001 bits, MSB first
  - `underrun=0`
- Host streams writes continuously during the active region:
  - `host_ready` drops exactly in cycles where `dreq=1`
  - every accepted write appears on `mem_*` one cycle later
  - no display underrun
- Force the RAM to return data 1 cycle late by stalling the `mem_rdata` model:
  - `underrun` rises on the first starved pop
  - state becomes `IDLE` and `pixel=0` until the next trigger
  - normal output resumes next frame with `underrun` still 1
- Assert `rst_n` low at line 200, pixel 300, for 1 cycle:
  - all outputs at reset values the next cycle
  - `pixel=0` until the trigger
  - the following frame is correct
- At the end of a frame, `fetch_addr` equals 19200 and no further reads are issued until the trigger. After the trigger the reads are issued to address 0 then address 1.
- Host write to address 40 during vertical blanking, then display of line 1: line 1 pixels 0–15 equal the written word.
